// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the 16x UART receiver
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state)
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running 16x oversample tick, one clk wide every CLK_FREQ/(BAUD*16) clocks
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 16x oversampling UART receiver, 8N1 by default
// Optional feature macro: UART_RX_PARITY_EN (8E1 with parity error reported as o_frame_err)
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err
);

  logic                 tick;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;

  baud_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync        <= 2'b11;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_err     <= 1'b0;
      o_rx_data   <= 8'h00;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[0], rx};
      rx_prev     <= rx_s;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Only a real 1->0 edge arms; a held-low line after an error stays here
          if (rx_prev && !rx_s) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_err  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'(MID_SAMPLE - 1)) begin
              tick_cnt <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              par_err  <= (rx_s != ^shift);
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s && !par_err) begin
                o_rx_data <= shift;
                o_rx_done <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb/tb_uart_rx_16x.sv - directed self-checking bench for uart_rx_16x (DIV = 10, 160 clk per bit)
module tb_uart_rx_16x;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int done_cyc = 0;
  int edge_cyc = 0;
  logic [7:0] got_q[$];

  uart_rx_16x #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .o_rx_data   (rx_data),
    .o_rx_done   (rx_done),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_cyc = cyc;
      got_q.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    edge_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit) rx = 1'b0;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int d0, e0, lat;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    settle();
    chk("reset_data", rx_data, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_bits(2);

    // Scenario 1: single 0x55 and its latency from the start edge
    send_byte(8'h55, 1'b1, 1'b0);
    wait_bits(2);
    settle();
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_data", rx_data, 8'h55);
    lat = done_cyc - edge_cyc;
    chk("s1_latency_in_1505_1535", (lat >= 1505 && lat <= 1535), 1'b1);

    // Scenario 2: back-to-back frames with no idle between them
    send_byte(8'hA3, 1'b1, 1'b0);
    send_byte(8'h0F, 1'b1, 1'b0);
    wait_bits(2);
    settle();
    chk("s2_done_cnt", done_cnt, 3);
    chk("s2_q_size", got_q.size(), 3);
    chk("s2_first", got_q[1], 8'hA3);
    chk("s2_second", got_q[2], 8'h0F);
    chk("s2_data_held", rx_data, 8'h0F);

    // Scenario 3: bad stop bit, then the line stays low as a break
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hFF, 1'b0, 1'b0);
    wait_bits(10);
    rx = 1'b1;
    wait_bits(3);
    settle();
    chk("s3_err_cnt", err_cnt - e0, 1);
    chk("s3_no_done", done_cnt - d0, 0);
    chk("s3_data_kept", rx_data, 8'h0F);

    // Scenario 4: 30-clk glitch on idle line, then 0x3C
    d0 = done_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_bits(3);
    settle();
    chk("s4_glitch_no_done", done_cnt - d0, 0);
    chk("s4_glitch_no_err", err_cnt - e0, 0);
    send_byte(8'h3C, 1'b1, 1'b0);
    wait_bits(2);
    settle();
    chk("s4_done_cnt", done_cnt - d0, 1);
    chk("s4_data", rx_data, 8'h3C);

    // Scenario 5: reset in the middle of data bit 4, then 0x81
    d0 = done_cnt;
    e0 = err_cnt;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    settle();
    chk("s5_rst_data", rx_data, 8'h00);
    chk("s5_rst_done", rx_done, 1'b0);
    chk("s5_rst_err", frame_err, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_bits(12);
    settle();
    chk("s5_abort_no_done", done_cnt - d0, 0);
    chk("s5_abort_no_err", err_cnt - e0, 0);
    send_byte(8'h81, 1'b1, 1'b0);
    wait_bits(2);
    settle();
    chk("s5_done_cnt", done_cnt - d0, 1);
    chk("s5_data", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
    // Scenario 6: even parity of 0x07 is 1
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h07, 1'b1, 1'b1);
    wait_bits(2);
    settle();
    chk("s6_good_done", done_cnt - d0, 1);
    chk("s6_good_data", rx_data, 8'h07);
    send_byte(8'h07, 1'b1, 1'b0);
    wait_bits(2);
    settle();
    chk("s6_bad_err", err_cnt - e0, 1);
    chk("s6_bad_no_done", done_cnt - d0, 1);
`endif

    chk("never_both_pulses", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
